// File: rtl/fetch_pkg.sv
// Shared types and sizing for the instruction-fetch front end.
package fetch_pkg;

    localparam int FETCH_DATA_W = 32;
    localparam int FETCH_ADDR_W = 32;
    localparam int FETCH_DEPTH  = 4;

    localparam int PTR_W = $clog2(FETCH_DEPTH);
    localparam int CNT_W = $clog2(FETCH_DEPTH) + 1;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_DATA_W-1:0] data;
    } fetch_entry_t;

    // Saturating 32-bit accumulate used by the optional performance counters.
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush and occupancy count; the head word is presented
// combinationally from storage and is only meaningful while empty is low.
module sync_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = FETCH_DEPTH,
    parameter int PW    = PTR_W,
    parameter int CW    = CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // NOTE: storage is deliberately not reset; count alone decides which words are live.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: credit-limited sequential requests, prefetch queue,
// redirect with stale-response discard. Define FETCH_PERF_EN for perf counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = FETCH_DATA_W,
    parameter int                    ADDR_WIDTH = FETCH_ADDR_W,
    parameter int                    DEPTH      = FETCH_DEPTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    PC_INC     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  busy
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]           perf_fetched,
    output logic [31:0]           perf_discarded
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [ADDR_WIDTH-1:0] fetch_pc, fetch_pc_nxt;
    logic [CW-1:0]         stale, stale_nxt;
    logic [CW-1:0]         outstanding;   // the in-flight pc FIFO occupancy
    logic [CW-1:0]         outstanding_nxt;
    logic [CW-1:0]         q_count;
    logic                  q_empty, pc_empty;
    logic [ADDR_WIDTH-1:0] pc_head;
    fetch_entry_t          q_in, q_head;
    logic                  credit, accept, rsp_ok, keep, drop, deliver;

    assign credit         = ({1'b0, q_count} + {1'b0, outstanding}) < (CW+1)'(DEPTH);
    assign imem_req_valid = rst && credit;
    assign imem_req_addr  = fetch_pc;
    assign accept         = imem_req_valid && imem_req_ready;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_ok         = imem_rsp_valid && !pc_empty;
    assign keep           = rsp_ok && (stale == '0) && !redirect_valid;
    assign drop           = rsp_ok && !keep;
    assign deliver        = instr_valid && instr_ready;

    assign outstanding_nxt = outstanding + CW'(accept) - CW'(rsp_ok);

    // NOTE: combinational next-state assigns every output first so no latch is inferred.
    always_comb begin
        fetch_pc_nxt = fetch_pc;
        stale_nxt    = stale;
        if (redirect_valid) begin
            fetch_pc_nxt = redirect_pc & ~ADDR_WIDTH'(3);
            stale_nxt    = outstanding_nxt;
        end else begin
            if (accept) fetch_pc_nxt = fetch_pc + ADDR_WIDTH'(PC_INC);
            if (drop)   stale_nxt    = stale - CW'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            stale    <= '0;
        end else begin
            fetch_pc <= fetch_pc_nxt;
            stale    <= stale_nxt;
        end
    end

    sync_fifo #(.WIDTH(ADDR_WIDTH), .DEPTH(DEPTH), .PW(PW), .CW(CW)) u_pc_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_data (fetch_pc),
        .pop       (rsp_ok),
        .flush     (1'b0),
        .head      (pc_head),
        .count     (outstanding),
        .empty     (pc_empty)
    );

    always_comb begin
        q_in      = '0;
        q_in.pc   = pc_head;
        q_in.data = imem_rsp_data;
    end

    sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH), .PW(PW), .CW(CW)) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (keep),
        .push_data (q_in),
        .pop       (deliver),
        .flush     (redirect_valid),
        .head      (q_head),
        .count     (q_count),
        .empty     (q_empty)
    );

    assign instr_valid = !q_empty;
    assign instr_data  = q_empty ? '0 : q_head.data;
    assign instr_pc    = q_empty ? '0 : q_head.pc;
    assign busy        = (outstanding != '0) || (q_count != '0);

`ifdef FETCH_PERF_EN
    logic [CW-1:0] flushed;
    // Entries still queued after this cycle's delivery are the ones a redirect throws away.
    assign flushed = redirect_valid ? (q_count - CW'(deliver)) : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_fetched   <= '0;
            perf_discarded <= '0;
        end else begin
            perf_fetched   <= sat_add32(perf_fetched, 32'(keep));
            perf_discarded <= sat_add32(perf_discarded, 32'(drop) + 32'(flushed));
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// scored against an epoch-based model of the fetch stream.
module tb_fetch_unit;

    localparam int          DW       = 32;
    localparam int          AW       = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic          clk;
    logic          rst;
    logic          imem_req_valid;
    logic          imem_req_ready;
    logic [AW-1:0] imem_req_addr;
    logic          imem_rsp_valid;
    logic [DW-1:0] imem_rsp_data;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          instr_valid;
    logic          instr_ready;
    logic [DW-1:0] instr_data;
    logic [AW-1:0] instr_pc;
    logic          busy;
`ifdef FETCH_PERF_EN
    logic [31:0]   perf_fetched;
    logic [31:0]   perf_discarded;
`endif

    fetch_unit #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH),
        .RESET_PC   (RESET_PC),
        .PC_INC     (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .busy           (busy)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_discarded (perf_discarded)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    // Reference model: requests in flight (tagged with the redirect epoch they were
    // issued in) and the words waiting for decode.
    req_t        inflight[$];
    ent_t        mq[$];
    logic [31:0] m_pc;
    int          m_epoch;
    bit          m_valid;
    longint      m_fetched;
    longint      m_disc;
    int          cyc;
    int          last_due;

    bit          drv_rst, drv_ready, drv_iready, drv_redirect, drv_bogus;
    logic [31:0] drv_rpc;
    int          lat_min, lat_max;

    logic        s_req_valid, s_iv, s_busy;
    logic [31:0] s_addr, s_ipc, s_idata;

    int total;
    int bad;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // One clock cycle: drive inputs on the falling edge, sample, score, advance the model.
    task automatic step();
        logic        exp_rv, exp_iv, exp_busy;
        logic [31:0] exp_addr, exp_ipc, exp_idata;
        req_t        cur;
        ent_t        ent;
        bit          rsp_real, accept, deliver, kept;
        int          due;

        @(negedge clk);
        exp_rv    = drv_rst && ((inflight.size() + mq.size()) < DEPTH);
        exp_addr  = m_pc;
        exp_iv    = (mq.size() > 0);
        exp_ipc   = exp_iv ? mq[0].pc : 32'h0;
        exp_idata = exp_iv ? mq[0].data : 32'h0;
        exp_busy  = (inflight.size() > 0) || (mq.size() > 0);

        rst            = drv_rst;
        imem_req_ready = drv_ready;
        instr_ready    = drv_iready;
        redirect_valid = drv_redirect;
        redirect_pc    = drv_rpc;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        rsp_real       = 1'b0;
        cur            = '{32'h0, 0, 0};
        if (drv_rst && inflight.size() > 0 && inflight[0].due <= cyc) begin
            cur            = inflight.pop_front();
            rsp_real       = 1'b1;
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memfn(cur.addr);
        end else if (drv_rst && drv_bogus && inflight.size() == 0) begin
            imem_rsp_valid = 1'b1;
        end

        #1;
        s_req_valid = imem_req_valid;
        s_addr      = imem_req_addr;
        s_iv        = instr_valid;
        s_ipc       = instr_pc;
        s_idata     = instr_data;
        s_busy      = busy;

        if (m_valid) begin
            total++; if (s_req_valid !== exp_rv) begin bad++; $display("FAIL req_valid cyc=%0d: got %b want %b", cyc, s_req_valid, exp_rv); end
            total++; if (s_addr !== exp_addr) begin bad++; $display("FAIL req_addr cyc=%0d: got %h want %h", cyc, s_addr, exp_addr); end
            total++; if (s_iv !== exp_iv) begin bad++; $display("FAIL instr_valid cyc=%0d: got %b want %b", cyc, s_iv, exp_iv); end
            total++; if (s_ipc !== exp_ipc) begin bad++; $display("FAIL instr_pc cyc=%0d: got %h want %h", cyc, s_ipc, exp_ipc); end
            total++; if (s_idata !== exp_idata) begin bad++; $display("FAIL instr_data cyc=%0d: got %h want %h", cyc, s_idata, exp_idata); end
            total++; if (s_busy !== exp_busy) begin bad++; $display("FAIL busy cyc=%0d: got %b want %b", cyc, s_busy, exp_busy); end
`ifdef FETCH_PERF_EN
            total++; if (perf_fetched !== 32'(m_fetched)) begin bad++; $display("FAIL perf_fetched cyc=%0d: got %0d want %0d", cyc, perf_fetched, m_fetched); end
            total++; if (perf_discarded !== 32'(m_disc)) begin bad++; $display("FAIL perf_discarded cyc=%0d: got %0d want %0d", cyc, perf_discarded, m_disc); end
`endif
        end

        if (!drv_rst) begin
            inflight.delete();
            mq.delete();
            m_pc      = RESET_PC;
            m_fetched = 0;
            m_disc    = 0;
            m_valid   = 1'b1;
        end else begin
            deliver = (mq.size() > 0) && drv_iready;
            if (deliver) ent = mq.pop_front();
            accept = exp_rv && drv_ready;
            if (accept) begin
                due = cyc + $urandom_range(lat_max, lat_min);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                inflight.push_back('{m_pc, m_epoch, due});
            end
            kept = rsp_real && (cur.epoch == m_epoch) && !drv_redirect;
            if (rsp_real && !kept) m_disc++;
            if (drv_redirect) begin
                m_disc += mq.size();
                mq.delete();
                m_epoch++;
                m_pc = drv_rpc & ~32'h3;
            end else if (accept) begin
                m_pc = m_pc + 32'd4;
            end
            if (kept) begin
                mq.push_back('{cur.addr, memfn(cur.addr)});
                m_fetched++;
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        drv_ready    = 1'b0;
        drv_iready   = 1'b0;
        drv_redirect = 1'b0;
        drv_bogus    = 1'b0;
        drv_rpc      = 32'h0;
        drv_rst      = 1'b0;
        step();
        step();
        drv_rst = 1'b1;
    endtask

    task automatic test_reset();
        lat_min = 1; lat_max = 1;
        do_reset();
        total++; if (s_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid: got %b want 0", s_req_valid); end
        total++; if (s_addr !== RESET_PC) begin bad++; $display("FAIL reset_req_addr: got %h want %h", s_addr, RESET_PC); end
        total++; if (s_iv !== 1'b0) begin bad++; $display("FAIL reset_instr_valid: got %b want 0", s_iv); end
        total++; if (s_idata !== 32'h0) begin bad++; $display("FAIL reset_instr_data: got %h want 0", s_idata); end
        total++; if (s_ipc !== 32'h0) begin bad++; $display("FAIL reset_instr_pc: got %h want 0", s_ipc); end
        total++; if (s_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", s_busy); end
        step();
        total++; if (s_req_valid !== 1'b1 || s_addr !== RESET_PC) begin bad++; $display("FAIL release_first_req: got v=%b a=%h want v=1 a=%h", s_req_valid, s_addr, RESET_PC); end
    endtask

    task automatic test_stream();
        lat_min = 1; lat_max = 1;
        do_reset();
        drv_ready  = 1'b1;
        drv_iready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            if (k < 3) begin
                total++; if (s_req_valid !== 1'b1 || s_addr !== 32'(4 * k)) begin bad++; $display("FAIL stream_req k=%0d: got v=%b a=%h want v=1 a=%h", k, s_req_valid, s_addr, 32'(4 * k)); end
            end
            if (k < 2) begin
                total++; if (s_iv !== 1'b0) begin bad++; $display("FAIL stream_early k=%0d: got instr_valid=%b want 0", k, s_iv); end
            end else begin
                total++; if (s_iv !== 1'b1 || s_ipc !== 32'(4 * (k - 2))) begin bad++; $display("FAIL stream_deliver k=%0d: got v=%b pc=%h want v=1 pc=%h", k, s_iv, s_ipc, 32'(4 * (k - 2))); end
            end
        end
    endtask

    task automatic test_backpressure();
        int          n_acc;
        logic [31:0] last_addr;
        lat_min = 1; lat_max = 1;
        do_reset();
        drv_ready  = 1'b1;
        drv_iready = 1'b0;
        n_acc = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (s_req_valid === 1'b1) n_acc++;
        end
        total++; if (n_acc != DEPTH) begin bad++; $display("FAIL bp_accepts: got %0d want %0d", n_acc, DEPTH); end
        total++; if (s_req_valid !== 1'b0) begin bad++; $display("FAIL bp_stall: got req_valid=%b want 0", s_req_valid); end
        drv_iready = 1'b1;
        step();
        total++; if (s_iv !== 1'b1 || s_ipc !== 32'h0) begin bad++; $display("FAIL bp_pop: got v=%b pc=%h want v=1 pc=0", s_iv, s_ipc); end
        drv_iready = 1'b0;
        n_acc      = 0;
        last_addr  = 32'hFFFF_FFFF;
        for (int k = 0; k < 4; k++) begin
            step();
            if (s_req_valid === 1'b1) begin n_acc++; last_addr = s_addr; end
        end
        total++; if (n_acc != 1 || last_addr !== 32'h10) begin bad++; $display("FAIL bp_refill: got n=%0d a=%h want n=1 a=00000010", n_acc, last_addr); end
    endtask

    task automatic test_redirect();
        bit found;
        lat_min = 3; lat_max = 3;
        do_reset();
        drv_iready = 1'b1;
        drv_ready  = 1'b1;
        step();
        step();
        drv_ready    = 1'b0;
        drv_redirect = 1'b1;
        drv_rpc      = 32'h103;
        step();
        total++; if (s_busy !== 1'b1 || s_iv !== 1'b0) begin bad++; $display("FAIL redir_setup: got busy=%b v=%b want busy=1 v=0", s_busy, s_iv); end
        drv_redirect = 1'b0;
        drv_ready    = 1'b1;
        step();
        total++; if (s_req_valid !== 1'b1 || s_addr !== 32'h100) begin bad++; $display("FAIL redir_new_req: got v=%b a=%h want v=1 a=00000100", s_req_valid, s_addr); end
        drv_ready = 1'b0;
        found     = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (s_iv === 1'b1) found = 1'b1;
        end
        total++; if (!found || s_ipc !== 32'h100 || s_idata !== memfn(32'h100)) begin bad++; $display("FAIL redir_first_instr: got found=%b pc=%h d=%h want pc=00000100 d=%h", found, s_ipc, s_idata, memfn(32'h100)); end
        step();
        total++; if (s_iv !== 1'b0 || s_busy !== 1'b0) begin bad++; $display("FAIL redir_drained: got v=%b busy=%b want 0 0", s_iv, s_busy); end
`ifdef FETCH_PERF_EN
        total++; if (perf_fetched !== 32'd1 || perf_discarded !== 32'd2) begin bad++; $display("FAIL redir_perf: got f=%0d d=%0d want f=1 d=2", perf_fetched, perf_discarded); end
`endif
    endtask

    task automatic test_redirect_collide();
        lat_min = 1; lat_max = 1;
        do_reset();
        drv_ready  = 1'b1;
        drv_iready = 1'b0;
        repeat (8) step();
        total++; if (s_iv !== 1'b1 || s_req_valid !== 1'b0) begin bad++; $display("FAIL coll_full: got v=%b rv=%b want v=1 rv=0", s_iv, s_req_valid); end
        drv_iready = 1'b1;
        step();
        total++; if (s_ipc !== 32'h0) begin bad++; $display("FAIL coll_pop0: got pc=%h want 0", s_ipc); end
        drv_iready = 1'b0;
        step();
        total++; if (s_req_valid !== 1'b1 || s_addr !== 32'h10) begin bad++; $display("FAIL coll_req: got v=%b a=%h want v=1 a=00000010", s_req_valid, s_addr); end
        drv_iready   = 1'b1;
        drv_redirect = 1'b1;
        drv_rpc      = 32'h200;
        step();
        total++; if (s_iv !== 1'b1 || s_ipc !== 32'h4) begin bad++; $display("FAIL coll_handshake: got v=%b pc=%h want v=1 pc=00000004", s_iv, s_ipc); end
        drv_iready   = 1'b0;
        drv_redirect = 1'b0;
        drv_ready    = 1'b0;
        step();
        total++; if (s_iv !== 1'b0 || s_busy !== 1'b0 || s_ipc !== 32'h0) begin bad++; $display("FAIL coll_empty: got v=%b busy=%b pc=%h want 0 0 0", s_iv, s_busy, s_ipc); end
`ifdef FETCH_PERF_EN
        total++; if (perf_fetched !== 32'd4 || perf_discarded !== 32'd3) begin bad++; $display("FAIL coll_perf: got f=%0d d=%0d want f=4 d=3", perf_fetched, perf_discarded); end
`endif
        drv_ready = 1'b1;
        step();
        total++; if (s_req_valid !== 1'b1 || s_addr !== 32'h200) begin bad++; $display("FAIL coll_new_req: got v=%b a=%h want v=1 a=00000200", s_req_valid, s_addr); end
    endtask

    task automatic test_reset_mid();
        lat_min = 3; lat_max = 3;
        do_reset();
        drv_ready  = 1'b1;
        drv_iready = 1'b0;
        repeat (6) step();
        total++; if (s_busy !== 1'b1 || s_iv !== 1'b1) begin bad++; $display("FAIL rmid_setup: got busy=%b v=%b want 1 1", s_busy, s_iv); end
        drv_rst = 1'b0;
        step();
        total++; if (s_req_valid !== 1'b0) begin bad++; $display("FAIL rmid_req_drop: got %b want 0", s_req_valid); end
        step();
        total++; if (s_iv !== 1'b0 || s_ipc !== 32'h0 || s_idata !== 32'h0) begin bad++; $display("FAIL rmid_instr: got v=%b pc=%h d=%h want all 0", s_iv, s_ipc, s_idata); end
        total++; if (s_busy !== 1'b0 || s_addr !== RESET_PC) begin bad++; $display("FAIL rmid_state: got busy=%b a=%h want 0 %h", s_busy, s_addr, RESET_PC); end
        drv_rst    = 1'b1;
        drv_iready = 1'b1;
        step();
        total++; if (s_req_valid !== 1'b1 || s_addr !== RESET_PC) begin bad++; $display("FAIL rmid_release: got v=%b a=%h want v=1 a=%h", s_req_valid, s_addr, RESET_PC); end
        repeat (10) step();
    endtask

    task automatic test_random();
        lat_min = 1; lat_max = 4;
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            drv_rst      = !($urandom_range(0, 299) == 0);
            drv_ready    = ($urandom_range(0, 9) < 7);
            drv_iready   = ($urandom_range(0, 9) < 6);
            drv_redirect = ($urandom_range(0, 19) == 0);
            drv_bogus    = ($urandom_range(0, 9) == 0);
            drv_rpc      = $urandom_range(0, 1) ? (32'hFFFF_FFE0 | ($urandom & 32'h1F)) : $urandom;
            step();
        end
        drv_rst      = 1'b1;
        drv_ready    = 1'b0;
        drv_iready   = 1'b1;
        drv_redirect = 1'b0;
        drv_bogus    = 1'b0;
        for (int k = 0; k < 40 && s_busy !== 1'b0; k++) step();
        total++; if (s_busy !== 1'b0) begin bad++; $display("FAIL rand_drain: got busy=%b want 0", s_busy); end
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        m_valid        = 1'b0;
        m_pc           = RESET_PC;
        m_epoch        = 0;
        m_fetched      = 0;
        m_disc         = 0;
        cyc            = 0;
        last_due       = 0;
        rst            = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;

        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_collide();
        test_reset_mid();
        test_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
